// File: rtl/btn_status_pkg.sv
// rtl/btn_status_pkg.sv - shared bit positions for the button status WireIn/WireOut words
package btn_status_pkg;

    // ctrl word (from WireIn)
    localparam int SNAP_BIT   = 0;
    localparam int CLR_BIT    = 1;
    localparam int MASK_LSB   = 8;

    // status_out word (to WireOut)
    localparam int DB_LSB     = 0;
    localparam int STICKY_LSB = 4;
    localparam int SAT_LSB    = 16;
    localparam int SEQ_LSB    = 24;
    localparam int SEQ_W      = 8;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-flop synchronizer and stability-counter debouncer
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_i,      // okClk
    input  logic reset_i,    // synchronous, active-high
    input  logic btn_raw_i,  // asynchronous button pin
    output logic db_o        // debounced level, 1 = pressed
);

    // Raw pin level of a released button; the synchronizer resets to it so
    // no phantom press is seen after reset.
    localparam logic        REL_LEVEL = BTN_ACTIVE_LOW;
    localparam logic [15:0] CNT_LAST  = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        pressed;
    logic        db_q;
    logic [15:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= REL_LEVEL;
            sync2_q <= REL_LEVEL;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

    // Any return to the accepted level restarts the count, so only a change
    // held for DEBOUNCE_CYCLES consecutive cycles is accepted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else if (pressed == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            db_q  <= pressed;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/button_status_capture.sv
// rtl/button_status_capture.sv - debounced button press counters with host snapshot/clear over WireIn/WireOut
module button_status_capture
    import btn_status_pkg::*;
#(
    parameter int NBTN            = 4,
    parameter int CNT_W           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic            okClk,       // host interface clock
    input  logic            reset,       // synchronous, active-high
    input  logic [NBTN-1:0] btn_in,      // raw button pins
    input  logic [31:0]     ctrl,        // snap_req, clear_req, clear_mask
    output logic [31:0]     status_out,  // live status word
    output logic [31:0]     count_out,   // counter snapshot
    output logic [NBTN-1:0] btn_db       // debounced pressed level
);

    if (NBTN * CNT_W != 32) begin : g_bad_width
        $error("button_status_capture: NBTN*CNT_W must equal 32");
    end
    if (NBTN > 4) begin : g_bad_nbtn
        $error("button_status_capture: status_out fields hold at most 4 buttons");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("button_status_capture: DEBOUNCE_CYCLES must be 1..65535");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NBTN-1:0]             db;
    logic [NBTN-1:0]             db_prev_q;
    logic [NBTN-1:0]             press;
    logic [1:0]                  ctrl_q;
    logic                        snap_edge;
    logic                        clr_edge;
    logic [NBTN-1:0]             clr_hit;
    logic [NBTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NBTN-1:0]             sticky_q, sticky_d;
    logic [NBTN-1:0]             sat_q, sat_d;
    logic [SEQ_W-1:0]            seq_q;
    logic [31:0]                 count_q;
    logic [31:0]                 status_q, status_d;
    logic                        ctrl_unused;

    assign ctrl_unused = ^{ctrl[31:MASK_LSB+NBTN], ctrl[MASK_LSB-1:CLR_BIT+1]};

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_debounce (
            .clk_i     (okClk),
            .reset_i   (reset),
            .btn_raw_i (btn_in[i]),
            .db_o      (db[i])
        );
    end

    assign press     = db & ~db_prev_q;
    assign snap_edge = ctrl[SNAP_BIT] & ~ctrl_q[0];
    assign clr_edge  = ctrl[CLR_BIT]  & ~ctrl_q[1];
    assign clr_hit   = clr_edge ? ctrl[MASK_LSB +: NBTN] : '0;

    // Clear is applied first, then a press on the same cycle lands on top of
    // it, so a press coinciding with a clear still counts as one.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        sat_d    = sat_q;
        for (int i = 0; i < NBTN; i++) begin
            if (clr_hit[i]) begin
                cnt_d[i]    = '0;
                sticky_d[i] = 1'b0;
                sat_d[i]    = 1'b0;
            end
            if (press[i]) begin
                sticky_d[i] = 1'b1;
                if (clr_hit[i]) begin
                    cnt_d[i] = CNT_W'(1);
                end else if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_d                       = '0;
        status_d[DB_LSB     +: NBTN]   = db;
        status_d[STICKY_LSB +: NBTN]   = sticky_q;
        status_d[SAT_LSB    +: NBTN]   = sat_q;
        status_d[SEQ_LSB    +: SEQ_W]  = seq_q;
    end

    // ctrl_q follows ctrl even in reset so a bit held high across reset
    // release does not look like a fresh host request.
    always_ff @(posedge okClk) begin
        ctrl_q <= ctrl[1:0];
        if (reset) begin
            db_prev_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= '0;
            sat_q     <= '0;
            seq_q     <= '0;
            count_q   <= '0;
            status_q  <= '0;
        end else begin
            db_prev_q <= db;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            sat_q     <= sat_d;
            status_q  <= status_d;
            // Snapshot takes the pre-clear counter values.
            if (snap_edge) begin
                count_q <= cnt_q;
                seq_q   <= seq_q + 1'b1;
            end
        end
    end

    assign status_out = status_q;
    assign count_out  = count_q;
    assign btn_db     = db;

endmodule

// File: tb/tb_button_status_capture.sv
// tb/tb_button_status_capture.sv - scoreboard bench for button_status_capture
module tb_button_status_capture;

    logic        okClk = 1'b0;
    logic        reset;
    logic [3:0]  btn_in;
    logic [31:0] ctrl;
    logic [31:0] status_out;
    logic [31:0] count_out;
    logic [3:0]  btn_db;

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] stat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 okClk = ~okClk;

    button_status_capture #(
        .NBTN            (4),
        .CNT_W           (8),
        .DEBOUNCE_CYCLES (8),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .okClk      (okClk),
        .reset      (reset),
        .btn_in     (btn_in),
        .ctrl       (ctrl),
        .status_out (status_out),
        .count_out  (count_out),
        .btn_db     (btn_db)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge okClk);
        #1;
    endtask

    task automatic press_btn(input int i);
        btn_in[i] = 1'b0;
        tick(12);
        btn_in[i] = 1'b1;
        tick(12);
    endtask

    task automatic snap(input logic [31:0] cnt, input logic [31:0] stat);
        exp_q.push_back('{cnt: cnt, stat: stat});
        ctrl[0] = 1'b1;
        tick(2);
        ctrl[0] = 1'b0;
        tick(4);
    endtask

    // Monitor: every change of snap_seq is one presented snapshot.
    initial begin
        logic [7:0] last_seq = 8'd0;
        exp_t       e;
        forever begin
            @(negedge okClk);
            if (reset === 1'b0 && status_out[31:24] !== last_seq) begin
                last_seq = status_out[31:24];
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_snapshot: got seq %h expected none", last_seq);
                end else begin
                    e = exp_q.pop_front();
                    check("count_out", count_out, e.cnt);
                    check("status_out", status_out, e.stat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic glitch_seen;
        reset  = 1'b1;
        ctrl   = 32'h3;
        btn_in = 4'hF;
        tick(5);
        reset = 1'b0;
        tick(4);
        check("reset_status", status_out, 32'h0);
        check("reset_count", count_out, 32'h0);
        check("reset_db", {28'h0, btn_db}, 32'h0);
        ctrl = 32'h0;
        tick(2);

        // debounce latency on btn0
        btn_in[0] = 1'b0;
        tick(9);
        check("db_latency_early", {31'h0, btn_db[0]}, 32'h0);
        tick(1);
        check("db_latency", {31'h0, btn_db[0]}, 32'h1);
        tick(3);
        btn_in[0] = 1'b1;
        tick(12);

        // 5-cycle glitch on btn1
        glitch_seen = 1'b0;
        btn_in[1] = 1'b0;
        tick(5);
        btn_in[1] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (btn_db[1]) glitch_seen = 1'b1;
        end
        check("glitch_reject", {31'h0, glitch_seen}, 32'h0);

        // three presses on btn2
        for (int k = 0; k < 3; k++) press_btn(2);
        snap(32'h0003_0001, 32'h0100_0050);

        // saturate btn3
        for (int k = 0; k < 260; k++) press_btn(3);
        snap(32'hFF03_0001, 32'h0208_00D0);

        // snapshot and clear of btn2 in the same cycle
        exp_q.push_back('{cnt: 32'hFF03_0001, stat: 32'h0308_0090});
        ctrl = 32'h0000_0403;
        tick(2);
        ctrl = 32'h0;
        tick(4);
        snap(32'hFF00_0001, 32'h0408_0090);

        // clear of btn1 coinciding with a btn1 press
        press_btn(1);
        btn_in[1] = 1'b0;
        tick(10);
        ctrl = 32'h0000_0202;
        tick(2);
        ctrl = 32'h0;
        tick(2);
        btn_in[1] = 1'b1;
        tick(12);
        snap(32'hFF00_0101, 32'h0508_00B0);

        // 256 snapshot toggles wrap snap_seq back to 5
        for (int k = 1; k <= 256; k++) begin
            exp_q.push_back('{cnt: 32'hFF00_0101,
                              stat: (32'((5 + k) % 256) << 24) | 32'h0008_00B0});
            ctrl[0] = 1'b1;
            tick(1);
            ctrl[0] = 1'b0;
            tick(1);
        end
        tick(5);
        check("seq_wrap", {24'h0, status_out[31:24]}, 32'h5);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick(1);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
